// File: rtl/reverse_pkg.sv
// Shared mode encodings for the bit-order transformer.
// Imported by the RTL and by stimulus code.
package reverse_pkg;

    localparam logic [1:0] MODE_PASS     = 2'b00;
    localparam logic [1:0] MODE_BITREV   = 2'b01;
    localparam logic [1:0] MODE_BYTESWAP = 2'b10;
    localparam logic [1:0] MODE_GRPREV   = 2'b11;

endpackage

// File: rtl/reverse_core.sv
// Combinational bit-order transform: pass, full reverse,
// byte swap, or reverse within GRP-bit groups.
module reverse_core
    import reverse_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GRP   = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    localparam int NB = WIDTH / 8;
    localparam int NG = WIDTH / GRP;

    if ((WIDTH % 8) != 0 || GRP < 2 || (WIDTH % GRP) != 0) begin : g_bad_param
        $error("reverse_core: WIDTH must be a multiple of 8 and of GRP, GRP >= 2");
    end

    logic [WIDTH-1:0] bitrev;
    logic [WIDTH-1:0] byteswap;
    logic [WIDTH-1:0] grprev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bitrev
        assign bitrev[i] = data[WIDTH-1-i];
    end

    for (genvar k = 0; k < NB; k++) begin : g_byteswap
        assign byteswap[k*8 +: 8] = data[(NB-1-k)*8 +: 8];
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        for (genvar j = 0; j < GRP; j++) begin : g_bit
            assign grprev[g*GRP+j] = data[g*GRP+GRP-1-j];
        end
    end

    always_comb begin
        result = data;
        unique case (mode)
            MODE_PASS:     result = data;
            MODE_BITREV:   result = bitrev;
            MODE_BYTESWAP: result = byteswap;
            MODE_GRPREV:   result = grprev;
            default:       result = data;
        endcase
    end

endmodule

// File: rtl/reverse_stream.sv
// Two-stage valid/ready pipeline around reverse_core, with a
// running count of completed output transfers.
module reverse_stream
    import reverse_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GRP   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [1:0]       s1_mode;
    logic [WIDTH-1:0] xform;
    logic             s2_adv;
    logic             accept;

    // Stage 2 refills whenever its slot is empty or being drained
    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = rst_n && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;

    reverse_core #(
        .WIDTH (WIDTH),
        .GRP   (GRP)
    ) u_core (
        .data   (s1_data),
        .mode   (s1_mode),
        .result (xform)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= MODE_PASS;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= MODE_PASS;
            beat_cnt  <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_mode  <= in_mode;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                out_valid <= 1'b1;
                out_data  <= xform;
                out_mode  <= s1_mode;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready) begin
                beat_cnt <= beat_cnt + CNT_ONE;
            end
        end
    end

endmodule
